// File: rtl/sig_filter_ctrl_pkg.sv
// Shared constants and event-word layout for the signal filter controller.
package sig_filter_ctrl_pkg;

    // Default width of the per-channel counter and length register.
    localparam int unsigned SFC_CNT_W       = 16;
    // Filter length loaded at reset: 1 us at 50 MHz.
    localparam int unsigned SFC_DEFAULT_LEN = 50;
    // Default depth of the event FIFO.
    localparam int unsigned SFC_FIFO_DEPTH  = 4;

    // Event word layout is {ch, level}: level in bit 0, channel index above it.
    localparam int unsigned EVT_LEVEL_POS   = 0;
    localparam int unsigned EVT_CH_LSB      = 1;

    // Width of a channel index; never narrower than one bit.
    function automatic int unsigned ch_width(input int unsigned num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/sig_filter_chan.sv
// One filtered channel: 2-flop synchronizer, mismatch counter, length register
// and the filtered output level.
module sig_filter_chan import sig_filter_ctrl_pkg::*; #(
    parameter int unsigned CNT_W       = SFC_CNT_W,
    parameter int unsigned DEFAULT_LEN = SFC_DEFAULT_LEN
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_sig,
    input  logic             i_cfg_wr,
    input  logic [CNT_W-1:0] i_cfg_len,
    output logic             o_level,
    output logic             o_fire,
    output logic             o_new_level
);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_len;
    logic             w_mismatch;
    logic             w_fire;

    // The output flips once the synchronized input has disagreed for len+1 cycles.
    assign w_mismatch  = (r_sync2 != r_level);
    assign w_fire      = w_mismatch && (r_cnt >= r_len);
    assign o_level     = r_level;
    assign o_fire      = w_fire;
    assign o_new_level = r_sync2;

    // Synchronizer, length register, counter and filtered level.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
            r_len   <= CNT_W'(DEFAULT_LEN);
        end else begin
            r_sync1 <= i_sig;
            r_sync2 <= r_sync1;
            // A length write leaves the running count alone.
            if (i_cfg_wr) begin
                r_len <= i_cfg_len;
            end
            if (w_fire) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else if (w_mismatch) begin
                if (r_cnt != '1) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/sig_filter_ctrl.sv
// Multi-channel glitch filter with a round-robin edge-event scheduler and FIFO.
module sig_filter_ctrl import sig_filter_ctrl_pkg::*; #(
    parameter  int unsigned NUM_CH      = 4,
    parameter  int unsigned CNT_W       = SFC_CNT_W,
    parameter  int unsigned DEFAULT_LEN = SFC_DEFAULT_LEN,
    parameter  int unsigned FIFO_DEPTH  = SFC_FIFO_DEPTH,
    localparam int unsigned CH_W        = ch_width(NUM_CH)
) (
    input  logic              clk_50mhz_in,
    input  logic              rst_in,
    input  logic [NUM_CH-1:0] sig_in,
    output logic [NUM_CH-1:0] sig_out,
    input  logic              cfg_wr,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_len,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [CH_W-1:0]   evt_ch,
    output logic              evt_level,
    output logic              evt_ovf,
    input  logic              ovf_clr
);

    localparam int unsigned EVT_W  = CH_W + 1;
    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH + 1);

    logic [NUM_CH-1:0] w_fire;
    logic [NUM_CH-1:0] w_new_level;
    logic [NUM_CH-1:0] r_pend;
    logic [NUM_CH-1:0] r_plev;
    logic [CH_W-1:0]   r_ptr;
    logic              r_ovf;
    logic [EVT_W-1:0]  r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [FCNT_W-1:0] r_count;
    logic              w_sel_found;
    logic [CH_W-1:0]   w_sel;
    logic              w_pop;
    logic              w_full;
    logic              w_push;
    logic [NUM_CH-1:0] w_push_oh;
    logic [NUM_CH-1:0] w_lost;
    logic [EVT_W-1:0]  w_entry;
    logic [EVT_W-1:0]  w_head;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        sig_filter_chan #(
            .CNT_W      (CNT_W),
            .DEFAULT_LEN(DEFAULT_LEN)
        ) u_chan (
            .i_clk      (clk_50mhz_in),
            .i_rst      (rst_in),
            .i_sig      (sig_in[g]),
            .i_cfg_wr   (cfg_wr && (cfg_ch == CH_W'(g))),
            .i_cfg_len  (cfg_len),
            .o_level    (sig_out[g]),
            .o_fire     (w_fire[g]),
            .o_new_level(w_new_level[g])
        );
    end

    // Channel reached k steps after the pointer, wrapping at NUM_CH.
    function automatic int unsigned rr_idx(input logic [CH_W-1:0] ptr, input int unsigned k);
        return (32'(ptr) + k) % NUM_CH;
    endfunction

    // Pick the first pending channel at or after the round-robin pointer.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel       = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (!w_sel_found && r_pend[c] && (rr_idx(r_ptr, k) == c)) begin
                    w_sel_found = 1'b1;
                    w_sel       = CH_W'(c);
                end
            end
        end
    end

    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign w_pop     = evt_valid && evt_ready;
    assign w_full    = (r_count == FCNT_W'(FIFO_DEPTH));
    assign w_push    = w_sel_found && (!w_full || w_pop);
    assign evt_valid = (r_count != '0);
    assign evt_ovf   = r_ovf;
    assign w_head    = r_mem[r_rd_ptr];
    assign evt_ch    = w_head[EVT_CH_LSB +: CH_W];
    assign evt_level = w_head[EVT_LEVEL_POS];

    // Per-channel push strobe, lost-event detection and the FIFO entry to write.
    always_comb begin
        w_push_oh = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            w_push_oh[c] = w_push && (w_sel == CH_W'(c));
        end
        // A transition lands on an already-pending channel that is not leaving now.
        w_lost                        = w_fire & r_pend & ~w_push_oh;
        w_entry                       = '0;
        w_entry[EVT_CH_LSB +: CH_W]   = w_sel;
        w_entry[EVT_LEVEL_POS]        = r_plev[w_sel];
    end

    // Pending flags, latched levels, round-robin pointer and sticky overflow.
    always_ff @(posedge clk_50mhz_in) begin
        if (rst_in) begin
            r_pend <= '0;
            r_plev <= '0;
            r_ptr  <= '0;
            r_ovf  <= 1'b0;
        end else begin
            r_pend <= (r_pend & ~w_push_oh) | w_fire;
            r_plev <= (r_plev & ~w_fire) | (w_new_level & w_fire);
            if (w_push) begin
                r_ptr <= (32'(w_sel) == NUM_CH - 1) ? '0 : w_sel + 1'b1;
            end
            // Set wins over clear.
            if (|w_lost) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // Event FIFO pointers and occupancy.
    always_ff @(posedge clk_50mhz_in) begin
        if (rst_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // FIFO storage; contents are don't-care while the slot is empty.
    always_ff @(posedge clk_50mhz_in) begin
        if (w_push && !rst_in) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

endmodule

// File: tb/tb_sig_filter_ctrl.sv
// Self-checking bench for sig_filter_ctrl: directed scenarios plus randomized
// traffic, all compared against a behavioural model kept in this file.
module tb_sig_filter_ctrl;

    localparam int NCH = 4;
    localparam int DL  = 50;
    localparam int FD  = 4;

    logic        clk = 1'b0;
    logic        rst_in;
    logic [3:0]  sig_in;
    logic [3:0]  sig_out;
    logic        cfg_wr;
    logic [1:0]  cfg_ch;
    logic [15:0] cfg_len;
    logic        evt_valid;
    logic        evt_ready;
    logic [1:0]  evt_ch;
    logic        evt_level;
    logic        evt_ovf;
    logic        ovf_clr;

    always #5 clk = ~clk;

    sig_filter_ctrl dut (
        .clk_50mhz_in(clk),
        .rst_in      (rst_in),
        .sig_in      (sig_in),
        .sig_out     (sig_out),
        .cfg_wr      (cfg_wr),
        .cfg_ch      (cfg_ch),
        .cfg_len     (cfg_len),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_ch      (evt_ch),
        .evt_level   (evt_level),
        .evt_ovf     (evt_ovf),
        .ovf_clr     (ovf_clr)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Behavioural model: input history, filtered level, mismatch run length,
    // pending events and an event queue.
    typedef struct {int ch; bit lvl;} ev_t;
    bit  m_h1 [NCH];
    bit  m_h2 [NCH];
    bit  m_lvl[NCH];
    bit  m_pend[NCH];
    bit  m_plev[NCH];
    int  m_run[NCH];
    int  m_len[NCH];
    int  m_ptr;
    bit  m_ovf;
    ev_t m_fifo[$];

    // Events taken by the consumer, in order.
    int pop_ch[$];
    int pop_lvl[$];
    int pop_cyc[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // Advance the model across one rising edge using the inputs now applied.
    function automatic void model_step();
        bit  fire[NCH];
        bit  pop;
        bit  push;
        bit  lost;
        int  sel;
        ev_t e;
        if (rst_in) begin
            for (int c = 0; c < NCH; c++) begin
                m_h1[c] = 0; m_h2[c] = 0; m_lvl[c] = 0; m_pend[c] = 0; m_plev[c] = 0;
                m_run[c] = 0; m_len[c] = DL;
            end
            m_ptr = 0;
            m_ovf = 0;
            m_fifo.delete();
            return;
        end
        pop = (m_fifo.size() > 0) && evt_ready;
        sel = -1;
        for (int k = 0; k < NCH; k++) begin
            if (sel < 0 && m_pend[(m_ptr + k) % NCH]) sel = (m_ptr + k) % NCH;
        end
        push = (sel >= 0) && ((m_fifo.size() < FD) || pop);
        for (int c = 0; c < NCH; c++) begin
            fire[c] = (m_h2[c] != m_lvl[c]) && (m_run[c] >= m_len[c]);
        end
        if (pop) void'(m_fifo.pop_front());
        if (push) begin
            e.ch  = sel;
            e.lvl = m_plev[sel];
            m_fifo.push_back(e);
            m_pend[sel] = 0;
            m_ptr = (sel + 1) % NCH;
        end
        lost = 0;
        for (int c = 0; c < NCH; c++) begin
            if (fire[c]) begin
                if (m_pend[c]) lost = 1;
                m_pend[c] = 1;
                m_plev[c] = m_h2[c];
            end
        end
        if (lost) m_ovf = 1;
        else if (ovf_clr) m_ovf = 0;
        for (int c = 0; c < NCH; c++) begin
            if (fire[c]) begin
                m_lvl[c] = m_h2[c];
                m_run[c] = 0;
            end else if (m_h2[c] != m_lvl[c]) begin
                m_run[c]++;
            end else begin
                m_run[c] = 0;
            end
        end
        if (cfg_wr) m_len[cfg_ch] = int'(cfg_len);
        for (int c = 0; c < NCH; c++) begin
            m_h2[c] = m_h1[c];
            m_h1[c] = sig_in[c];
        end
    endfunction

    task automatic compare_all();
        logic [3:0] exp_out;
        for (int c = 0; c < NCH; c++) exp_out[c] = m_lvl[c];
        check_eq("sig_out", 32'(sig_out), 32'(exp_out));
        check_eq("evt_valid", 32'(evt_valid), 32'(m_fifo.size() > 0));
        if (m_fifo.size() > 0) begin
            check_eq("evt_ch", 32'(evt_ch), m_fifo[0].ch);
            check_eq("evt_level", 32'(evt_level), 32'(m_fifo[0].lvl));
        end
        check_eq("evt_ovf", 32'(evt_ovf), 32'(m_ovf));
    endtask

    // One clock: note any handshake, step the model, then sample after the edge.
    task automatic tick();
        if (evt_valid && evt_ready) begin
            pop_ch.push_back(int'(evt_ch));
            pop_lvl.push_back(int'(evt_level));
            pop_cyc.push_back(cyc);
        end
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        compare_all();
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
    endtask

    task automatic write_len(input int ch, input int len);
        cfg_wr  = 1'b1;
        cfg_ch  = 2'(ch);
        cfg_len = 16'(len);
        tick();
        cfg_wr  = 1'b0;
    endtask

    task automatic clear_pops();
        pop_ch.delete();
        pop_lvl.delete();
        pop_cyc.delete();
    endtask

    initial begin
        bit seen;
        rst_in    = 1'b1;
        sig_in    = '0;
        cfg_wr    = 1'b0;
        cfg_ch    = '0;
        cfg_len   = '0;
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;

        // Reset state and default latency.
        tick();
        check_eq("rst_sig_out", 32'(sig_out), 32'd0);
        check_eq("rst_valid", 32'(evt_valid), 32'd0);
        check_eq("rst_ovf", 32'(evt_ovf), 32'd0);
        rst_in = 1'b0;
        sig_in = 4'b0001;
        for (int e = 1; e <= 54; e++) begin
            tick();
            if (e == 52) check_eq("lat_before", 32'(sig_out[0]), 32'd0);
            if (e == 53) begin
                check_eq("lat_rise", 32'(sig_out[0]), 32'd1);
                check_eq("lat_evt_early", 32'(evt_valid), 32'd0);
            end
            if (e == 54) begin
                check_eq("lat_evt_valid", 32'(evt_valid), 32'd1);
                check_eq("lat_evt_ch", 32'(evt_ch), 32'd0);
                check_eq("lat_evt_lvl", 32'(evt_level), 32'd1);
            end
        end
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;

        // A 40-cycle pulse must not get through a length-50 filter.
        seen = 0;
        sig_in[1] = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (sig_out[1] || evt_valid) seen = 1;
        end
        sig_in[1] = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (sig_out[1] || evt_valid) seen = 1;
        end
        check_eq("glitch", 32'(seen), 32'd0);

        // Zero length gives a one-cycle filter.
        write_len(2, 0);
        clear_pops();
        sig_in[2] = 1'b1;
        tick();
        tick();
        check_eq("zero_before", 32'(sig_out[2]), 32'd0);
        tick();
        check_eq("zero_rise", 32'(sig_out[2]), 32'd1);
        tick();
        check_eq("zero_evt_ch", 32'(evt_ch), 32'd2);
        evt_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        evt_ready = 1'b0;
        check_eq("zero_evt_count", pop_ch.size(), 32'd1);

        // Round-robin across all channels from pointer 0.
        sig_in = '0;
        do_reset();
        for (int i = 0; i < 3; i++) tick();
        clear_pops();
        evt_ready = 1'b1;
        sig_in    = 4'b1111;
        for (int i = 0; i < 60; i++) tick();
        check_eq("rr_count", pop_ch.size(), 32'd4);
        for (int i = 0; i < pop_ch.size(); i++) begin
            check_eq("rr_order", pop_ch[i], i);
            check_eq("rr_consec", pop_cyc[i] - pop_cyc[0], i);
        end
        evt_ready = 1'b0;

        // Backpressure: fill the FIFO, then overflow one pending channel.
        sig_in = '0;
        do_reset();
        for (int c = 0; c < NCH; c++) write_len(c, 2);
        sig_in = 4'b1111;
        for (int i = 0; i < 10; i++) tick();
        check_eq("bp_full_valid", 32'(evt_valid), 32'd1);
        sig_in[0] = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check_eq("bp_pending_ovf", 32'(evt_ovf), 32'd0);
        sig_in[0] = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check_eq("bp_ovf", 32'(evt_ovf), 32'd1);
        clear_pops();
        evt_ready = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        evt_ready = 1'b0;
        check_eq("bp_drain_count", pop_ch.size(), 32'd5);
        if (pop_ch.size() == 5) begin
            check_eq("bp_last_ch", pop_ch[4], 32'd0);
            check_eq("bp_last_lvl", pop_lvl[4], 32'd1);
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check_eq("ovf_clear", 32'(evt_ovf), 32'd0);

        // Reset in the middle of activity restores defaults.
        sig_in = '0;
        do_reset();
        write_len(0, 0);
        write_len(2, 0);
        write_len(1, 7);
        sig_in = 4'b0111;
        for (int i = 0; i < 14; i++) tick();
        sig_in[3] = 1'b1;
        for (int i = 0; i < 33; i++) tick();
        rst_in = 1'b1;
        sig_in = 4'b0010;
        tick();
        rst_in = 1'b0;
        check_eq("mid_rst_valid", 32'(evt_valid), 32'd0);
        check_eq("mid_rst_out", 32'(sig_out), 32'd0);
        for (int e = 1; e <= 53; e++) begin
            tick();
            if (e == 52) check_eq("mid_rst_len_before", 32'(sig_out[1]), 32'd0);
            if (e == 53) check_eq("mid_rst_len_rise", 32'(sig_out[1]), 32'd1);
        end

        // Randomized traffic with bursts of backpressure.
        for (int n = 0; n < 4000; n++) begin
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 11) == 0) sig_in[c] = ~sig_in[c];
            end
            cfg_wr  = ($urandom_range(0, 31) == 0);
            cfg_ch  = 2'($urandom_range(0, 3));
            cfg_len = 16'($urandom_range(0, 6));
            if ((n % 300) < 150) evt_ready = ($urandom_range(0, 7) == 0);
            else evt_ready = ($urandom_range(0, 1) == 1);
            ovf_clr = ($urandom_range(0, 39) == 0);
            rst_in  = ($urandom_range(0, 999) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
